// File: rtl/servo_pwm_sched.sv
// -----------------------------------------------------------------------------
// servo_pwm_sched
//   Multi-channel servo PWM scheduler. One shared frame counter drives N_CH
//   pulse outputs. Position commands land in per-channel shadow registers and
//   move to the active registers only at a frame boundary, so a pulse is never
//   cut short or stretched mid-frame.
//
// Optional feature (compile-time macro SERVO_STAGGER_EN):
//   Channel k's pulse window is shifted by k*STAGGER_CYC cycles inside the
//   frame so servo inrush current is spread out. Frame start and the commit
//   point do not move.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   en           run request (level); dropping it lets the current frame finish
//   wr_valid     write request
//   wr_ready     write accept
//   wr_ch[2:0]   target channel
//   wr_pos[7:0]  position command 0..255
//   pwm_out      servo pulse outputs, bit k is channel k
//   frame_start  one-cycle pulse aligned with the first pulse cycle of a frame
//   busy         high while RUN or DRAIN
//   bad_ch       one-cycle pulse after an accepted write with wr_ch >= N_CH
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Write handshake: a transfer happens on a clock edge where wr_valid and
// wr_ready are both 1. wr_ready does not depend on wr_valid; it is low during
// reset and in the commit cycle only, so the shadow registers never change on
// the same edge that copies them into the active registers.
// -----------------------------------------------------------------------------
module servo_pwm_sched #(
    parameter int N_CH       = 4,
    parameter int PERIOD_CYC = 2000000,
    parameter int MIN_CYC    = 100000,
    parameter int STEP_CYC   = 392,
    parameter int POS_RST    = 128
`ifdef SERVO_STAGGER_EN
    ,
    parameter int STAGGER_CYC = 250000
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_ch,
    input  logic [7:0]      wr_pos,
    output logic [N_CH-1:0] pwm_out,
    output logic            frame_start,
    output logic            busy,
    output logic            bad_ch,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);
    localparam int LEN_MAX = MIN_CYC + 255 * STEP_CYC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      shadow [N_CH];
    logic [7:0]      active [N_CH];
    logic            rdy_q;
    logic [31:0]     len [N_CH];
    logic [N_CH-1:0] hit;
    logic [31:0]     cnt_ext;
    logic            commit;
    logic            accept;
    logic            ch_ok;

    assign commit    = (state != IDLE) && (cnt == LAST);
    assign wr_ready  = rdy_q && !commit;
    assign accept    = wr_valid && wr_ready;
    assign ch_ok     = ({29'd0, wr_ch} < 32'(N_CH));
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign cnt_ext   = 32'(cnt);

    // Pulse lengths at full 32-bit width, and the per-channel in-window test.
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_CH; k++) begin
            len[k] = 32'(MIN_CYC) + 32'(active[k]) * 32'(STEP_CYC);
`ifdef SERVO_STAGGER_EN
            hit[k] = (cnt_ext >= 32'(k * STAGGER_CYC)) &&
                     (cnt_ext < 32'(k * STAGGER_CYC) + len[k]);
`else
            hit[k] = (cnt_ext < len[k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rdy_q       <= 1'b0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
            bad_ch      <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                shadow[k] <= 8'(POS_RST);
                active[k] <= 8'(POS_RST);
            end
        end else begin
            rdy_q       <= 1'b1;
            // Outputs are one cycle behind the counter, so the pulse rises
            // the cycle after the counter reaches 0.
            pwm_out     <= (state != IDLE) ? hit : '0;
            frame_start <= (state == RUN) && (cnt == '0);
            bad_ch      <= accept && !ch_ok;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state  <= RUN;
                        active <= shadow;
                    end
                end
                RUN, DRAIN: begin
                    if (commit) begin
                        cnt    <= '0;
                        active <= shadow;
                        // A draining block always stops here; a running one
                        // stops only if en has already dropped.
                        if (!en || state == DRAIN) state <= IDLE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        state <= en ? RUN : DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept && ch_ok) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (wr_ch == 3'(k)) shadow[k] <= wr_pos;
                end
            end
        end
    end

    // Parameter sanity: every pulse window must end inside the frame.
    always_ff @(posedge clk) begin
        assert (LEN_MAX < PERIOD_CYC);
`ifdef SERVO_STAGGER_EN
        assert ((N_CH - 1) * STAGGER_CYC + LEN_MAX < PERIOD_CYC);
`endif
    end

endmodule

// File: tb/tb_servo_pwm_sched.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_sched
//   Directed + randomized bench for servo_pwm_sched with a small frame
//   (PERIOD_CYC=1000, MIN_CYC=50, STEP_CYC=2, N_CH=4). The reference model
//   tracks the frame phase (ph = cycles since the frame_start sample, -1 for
//   the cycle before it) and the shadow/active positions; expected outputs are
//   derived from pulse windows [k*STAGGER, k*STAGGER + MIN + pos*STEP).
// -----------------------------------------------------------------------------
module tb_servo_pwm_sched;

    localparam int N_CH       = 4;
    localparam int PERIOD_CYC = 1000;
    localparam int MIN_CYC    = 50;
    localparam int STEP_CYC   = 2;
    localparam int POS_RST    = 128;
`ifdef SERVO_STAGGER_EN
    localparam int STAGGER    = 100;
`else
    localparam int STAGGER    = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            wr_valid;
    logic            wr_ready;
    logic [2:0]      wr_ch;
    logic [7:0]      wr_pos;
    logic [N_CH-1:0] pwm_out;
    logic            frame_start;
    logic            busy;
    logic            bad_ch;
    logic [1:0]      state_dbg;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    servo_pwm_sched #(
        .N_CH       (N_CH),
        .PERIOD_CYC (PERIOD_CYC),
        .MIN_CYC    (MIN_CYC),
        .STEP_CYC   (STEP_CYC),
        .POS_RST    (POS_RST)
`ifdef SERVO_STAGGER_EN
        ,
        .STAGGER_CYC(STAGGER)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_pos     (wr_pos),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .busy       (busy),
        .bad_ch     (bad_ch),
        .state_dbg  (state_dbg)
    );

    // ---------------- counters ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ---------------- reference model ----------------
    int m_ph;
    bit m_busy, m_drain, m_rst_done, m_fs, m_bad, m_acc;
    int m_shadow [N_CH];
    int m_active [N_CH];

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q [$];   // expected frame_start cycle stamps
    int obs_hi [N_CH];
    int exp_hi [N_CH];
    int mism_pwm [N_CH];
    int first_hi [N_CH];
    int mism_fs, mism_busy, mism_rdy, mism_bad;
    int obs_fs, obs_bad, obs_busy_low, win;

    function automatic int len_of(input int pos);
        return MIN_CYC + pos * STEP_CYC;
    endfunction

    function automatic bit exp_rdy();
        return m_rst_done && !(m_busy && m_ph == PERIOD_CYC - 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_drain = 0; m_ph = -1; m_rst_done = 0;
        m_fs = 0; m_bad = 0; m_acc = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_shadow[k] = POS_RST;
            m_active[k] = POS_RST;
        end
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_edge();
        int c;
        bit commit_now;
        c = wr_ch;
        if (!rst) begin
            model_reset();
            return;
        end
        m_acc      = wr_valid && exp_rdy();
        commit_now = m_busy && m_ph == PERIOD_CYC - 2;
        m_fs       = m_busy && !m_drain && m_ph == -1;
        m_bad      = m_acc && c >= N_CH;
        m_rst_done = 1;
        if (!m_busy) begin
            if (en) begin
                m_active = m_shadow;
                m_busy   = 1;
                m_drain  = 0;
                m_ph     = -1;
            end
        end else if (commit_now) begin
            m_active = m_shadow;
            m_ph     = -1;
            if (!en || m_drain) m_busy = 0;
            m_drain  = 0;
        end else begin
            m_ph++;
            m_drain = !en;
        end
        if (m_acc && c < N_CH) m_shadow[c] = wr_pos;
    endtask

    task automatic clr();
        for (int k = 0; k < N_CH; k++) begin
            obs_hi[k] = 0; exp_hi[k] = 0; mism_pwm[k] = 0; first_hi[k] = -1;
        end
        mism_fs = 0; mism_busy = 0; mism_rdy = 0; mism_bad = 0;
        obs_fs = 0; obs_bad = 0; obs_busy_low = 0; win = 0;
    endtask

    // One clock: predict, step the DUT, sample #1 after the edge, compare.
    task automatic cycle();
        bit e;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < N_CH; k++) begin
            e = m_busy && m_ph >= k * STAGGER && m_ph < k * STAGGER + len_of(m_active[k]);
            if (pwm_out[k] === 1'b1) begin
                obs_hi[k]++;
                if (first_hi[k] < 0) first_hi[k] = win;
            end
            if (e) exp_hi[k]++;
            if (pwm_out[k] !== e) mism_pwm[k]++;
        end
        if (m_fs) exp_q.push_back(32'(cyc));
        if (frame_start === 1'b1) begin
            obs_fs++;
            if (exp_q.size() == 0) mism_fs++;
            else if (exp_q.pop_front() != 32'(cyc)) mism_fs++;
        end else if (frame_start !== 1'b0) mism_fs++;
        if (busy !== m_busy) mism_busy++;
        if (busy !== 1'b1) obs_busy_low++;
        if (wr_ready !== exp_rdy()) mism_rdy++;
        if (bad_ch !== m_bad) mism_bad++;
        if (bad_ch === 1'b1) obs_bad++;
        cyc++;
        win++;
    endtask

    task automatic to_ph(input int t, input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (m_ph != t && n < 3000);
        if (m_ph != t) check({"timeout_", tag}, 32'(m_ph), 32'(t));
    endtask

    // Hold wr_valid until the handshake completes; report cycles spent waiting.
    task automatic do_write(input int ch, input int pos, output int low_cnt);
        int n;
        wr_valid = 1'b1;
        wr_ch    = 3'(ch);
        wr_pos   = 8'(pos);
        low_cnt  = 0;
        n        = 0;
        do begin
            if (wr_ready !== 1'b1) low_cnt++;
            cycle();
            n++;
        end while (!m_acc && n < 10);
        wr_valid = 1'b0;
        if (!m_acc) check("timeout_write", 32'(n), 32'(0));
    endtask

    task automatic checkpoint(input string tag);
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("%s_hi_ch%0d", tag, k), obs_hi[k], exp_hi[k]);
            check($sformatf("%s_shape_ch%0d", tag, k), mism_pwm[k], 0);
        end
        check({tag, "_fs_mism"}, mism_fs, 0);
        check({tag, "_fs_missing"}, exp_q.size(), 0);
        check({tag, "_busy"}, mism_busy, 0);
        check({tag, "_wr_ready"}, mism_rdy, 0);
        check({tag, "_bad_ch"}, mism_bad, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lc;
        int pos_h;
        int ph;
        int nw;

        rst = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_pos = '0;
        model_reset();
        clr();

        // Reset state
        repeat (3) cycle();
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bad_ch", 32'(bad_ch), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        rst = 1'b1;
        cycle();
        check("rdy_after_release", 32'(wr_ready), 1);
        checkpoint("reset");

        // Free run with reset positions
        en = 1'b1;
        cycle();
        check("busy_start", 32'(busy), 1);
        clr();
        to_ph(-1, "f0");
        for (int k = 0; k < N_CH; k++) check($sformatf("base_len_ch%0d", k), obs_hi[k], 306);
        check("base_fs", obs_fs, 1);
        check("base_rise3_vs_0", 32'(first_hi[3] - first_hi[0]), 32'(3 * STAGGER));
        checkpoint("frame0");

        // Mid-frame writes take effect next frame only
        clr();
        to_ph(400, "wr");
        do_write(1, 0, lc);
        do_write(2, 255, lc);
        to_ph(-1, "wr_cur");
        check("wr_cur_ch1", obs_hi[1], 306);
        check("wr_cur_ch2", obs_hi[2], 306);
        checkpoint("wr_cur");
        clr();
        to_ph(-1, "wr_next");
        check("wr_next_ch0", obs_hi[0], 306);
        check("wr_next_ch1", obs_hi[1], 50);
        check("wr_next_ch2", obs_hi[2], 560);
        check("wr_next_ch3", obs_hi[3], 306);
        checkpoint("wr_next");

        // Write held across the commit cycle
        pos_h = $urandom_range(0, 255);
        if (pos_h == 128) pos_h = 77;
        clr();
        to_ph(PERIOD_CYC - 2, "hold");
        do_write(0, pos_h, lc);
        check("hold_ready_low_cycles", lc, 1);
        to_ph(-1, "hold_a");
        check("hold_old_len_two_frames", obs_hi[0], 612);
        checkpoint("hold_a");
        clr();
        to_ph(-1, "hold_b");
        check("hold_new_len", obs_hi[0], len_of(pos_h));
        checkpoint("hold_b");

        // Out-of-range channel
        clr();
        to_ph(300, "bad");
        do_write(6, $urandom_range(0, 255), lc);
        to_ph(-1, "bad_a");
        check("bad_pulse_count", obs_bad, 1);
        checkpoint("bad_a");
        clr();
        to_ph(-1, "bad_b");
        check("bad_keep_ch0", obs_hi[0], len_of(pos_h));
        check("bad_keep_ch1", obs_hi[1], 50);
        check("bad_keep_ch2", obs_hi[2], 560);
        check("bad_keep_ch3", obs_hi[3], 306);
        checkpoint("bad_b");

        // Randomized writes, several frames
        for (int f = 0; f < 5; f++) begin
            clr();
            ph = $urandom_range(0, 200);
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                to_ph(ph, "rand");
                do_write($urandom_range(0, 7), $urandom_range(0, 255), lc);
                ph = m_ph + $urandom_range(1, 250);
            end
            to_ph(-1, "rand_end");
            checkpoint($sformatf("rand%0d", f));
        end

        // Drain: en drops at counter=100 with ch0=255
        clr();
        to_ph(10, "pre_drain");
        do_write(0, 255, lc);
        to_ph(-1, "pre_drain_end");
        checkpoint("pre_drain");
        clr();
        to_ph(99, "drain");
        en = 1'b0;
        repeat (1200) cycle();
        check("drain_ch0_len", obs_hi[0], 560);
        check("drain_fs_count", obs_fs, 1);
        check("drain_busy_end", 32'(busy), 0);
        checkpoint("drain");

        // Separate run: en drops at counter=100, returns at counter=500
        en = 1'b1;
        cycle();
        clr();
        to_ph(99, "rerun_off");
        en = 1'b0;
        to_ph(499, "rerun_on");
        en = 1'b1;
        to_ph(-1, "rerun_a");
        to_ph(-1, "rerun_b");
        check("rerun_fs_count", obs_fs, 2);
        check("rerun_busy_gap", obs_busy_low, 0);
        checkpoint("rerun");

        // Reset mid-pulse at counter=200
        clr();
        to_ph(199, "rst_mid");
        rst = 1'b0;
        cycle();
        check("rst_mid_pwm", 32'(pwm_out), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_wr_ready", 32'(wr_ready), 0);
        rst = 1'b1;
        cycle();
        checkpoint("rst_mid");
        clr();
        to_ph(-1, "post_rst");
        for (int k = 0; k < N_CH; k++) check($sformatf("post_rst_len_ch%0d", k), obs_hi[k], 306);
        check("post_rst_rise3_vs_0", 32'(first_hi[3] - first_hi[0]), 32'(3 * STAGGER));
        checkpoint("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
